pipelined_adder_tree: RTL and testbench

Parametrised, fully pipelined binary adder tree that sums N = 2**LOG2_N operands of WIDTH bits each into one WIDTH+LOG2_N-bit result.
- Next generation of the fixed 8-input tree: operand count, width and signedness are parameters, and the pipeline carries a valid/ready handshake with backpressure.
- Sits between operand-producing datapaths and downstream consumers; accepts one operand vector per cycle when not stalled.

---
 rtl/pipelined_adder_tree.sv | 128 ++++++++++++
 tb/tb_pipelined_adder_tree.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//
// Fully pipelined binary adder tree. It sums N = 2**LOG2_N operands of WIDTH
// bits each into one exact WIDTH+LOG2_N bit result. A valid/ready handshake
// with whole-pipeline backpressure sits around the datapath.
//
// Parameters:
//   WIDTH   bits per input operand (>= 1)
//   LOG2_N  number of adder levels; operand count N = 2**LOG2_N (1..6)
//   SIGNED  0 = operands unsigned (zero-extend), 1 = two's complement (sign-extend)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every valid and data register
//   in_data    packed operands, operand i at [i*WIDTH +: WIDTH]
//   in_valid   in_data carries a vector this cycle
//   in_ready   the tree accepts in_data this cycle (never depends on in_valid)
//   out_sum    sum of all N operands of the oldest vector in the tree
//   out_valid  out_sum holds a result
//   out_ready  the consumer takes out_sum this cycle
//
// Structure: stage 0 registers the raw operands. Stage k (1..LOG2_N) registers
// the level-k pairwise sums, N/2**k of them, each WIDTH+k bits wide. The last
// stage drives out_sum/out_valid. One global enable advances every stage
// together, so a stall freezes bubbles as well as data.

module pipelined_adder_tree #(
  parameter int WIDTH  = 17,
  parameter int LOG2_N = 3,
  parameter int SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(WIDTH<<LOG2_N)-1:0]    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH+LOG2_N-1:0]       out_sum,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int   N   = 1 << LOG2_N;
  localparam logic EXT = (SIGNED != 0);

  logic              en;
  logic [LOG2_N:0]   valid_q;
  logic [LOG2_N:0]   valid_d;
  logic [WIDTH-1:0]  op_q [N];

  // The pipeline may advance whenever the output register is empty or being
  // drained this cycle.
  assign en        = !valid_q[LOG2_N] || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_q[LOG2_N];

  // Valid bits shift as one chain; bubbles move along with the data.
  always_comb begin
    valid_d = valid_q;
    if (en) begin
      valid_d = {valid_q[LOG2_N-1:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Stage 0 captures the raw operands only for real vectors, so the data
  // registers keep their contents across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        op_q[i] <= '0;
      end
    end else if (en && in_valid) begin
      for (int i = 0; i < N; i++) begin
        op_q[i] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar k = 1; k <= LOG2_N; k++) begin : g_lvl
    localparam int IW = WIDTH + k - 1;
    localparam int SW = WIDTH + k;
    localparam int M  = N >> k;

    logic [IW-1:0] in_w  [2*M];
    logic [SW-1:0] sum_d [M];
    logic [SW-1:0] sum_q [M];

    // Level 1 reads the operand registers; deeper levels read the sums of the
    // level before, which are exactly one bit narrower than this level.
    for (genvar j = 0; j < 2*M; j++) begin : g_in
      if (k == 1) begin : g_first
        assign in_w[j] = op_q[j];
      end else begin : g_next
        assign in_w[j] = g_lvl[k-1].sum_q[j];
      end
    end

    // Each operand grows by one bit before the add, so the sum never overflows.
    always_comb begin
      for (int j = 0; j < M; j++) begin
        sum_d[j] = {EXT & in_w[2*j][IW-1], in_w[2*j]}
                 + {EXT & in_w[2*j+1][IW-1], in_w[2*j+1]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < M; j++) begin
          sum_q[j] <= '0;
        end
      end else if (en && valid_q[k-1]) begin
        for (int j = 0; j < M; j++) begin
          sum_q[j] <= sum_d[j];
        end
      end
    end
  end

  assign out_sum = g_lvl[LOG2_N].sum_q[0];

endmodule

// File: tb/tb_pipelined_adder_tree.sv
module tb_pipelined_adder_tree;

  localparam int W  = 17;
  localparam int L  = 3;
  localparam int N  = 8;
  localparam int DW = W * N;
  localparam int OW = W + L;

  typedef struct {
    logic [DW-1:0] data;
    logic [OW-1:0] expU;
    logic [OW-1:0] expS;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic          inReadyS;
  logic [OW-1:0] outSum;
  logic [OW-1:0] outSumS;
  logic          outValid;
  logic          outValidS;
  logic          outReady;

  int compares;
  int miscompares;

  vec_t          vecs [7];
  logic [OW-1:0] expQ [$];

  pipelined_adder_tree #(.WIDTH(W), .LOG2_N(L), .SIGNED(0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out_sum   (outSum),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  pipelined_adder_tree #(.WIDTH(W), .LOG2_N(L), .SIGNED(1)) u_dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReadyS),
    .out_sum   (outSumS),
    .out_valid (outValidS),
    .out_ready (outReady)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] pack8(input logic [W-1:0] o0, input logic [W-1:0] o1,
                                          input logic [W-1:0] o2, input logic [W-1:0] o3,
                                          input logic [W-1:0] o4, input logic [W-1:0] o5,
                                          input logic [W-1:0] o6, input logic [W-1:0] o7);
    return {o7, o6, o5, o4, o3, o2, o1, o0};
  endfunction

  // Operand i = base + i*step.
  function automatic logic [DW-1:0] packSeq(input int base, input int step);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = W'(base + i*step);
    end
    return r;
  endfunction

  // Reference sum: extend every operand to the result width and add linearly.
  function automatic logic [OW-1:0] sumModel(input logic [DW-1:0] d, input bit isSigned);
    logic [OW-1:0] acc;
    logic [W-1:0]  op;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      op  = d[i*W +: W];
      acc = acc + (isSigned ? {{L{op[W-1]}}, op} : {{L{1'b0}}, op});
    end
    return acc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic v);
    inData  = d;
    inValid = v;
  endtask

  // One isolated vector: checks acceptance, 4-cycle latency, both sums and a
  // single-cycle out_valid pulse.
  task automatic runOneVector(input string name, input logic [DW-1:0] d,
                              input logic [OW-1:0] expU, input logic [OW-1:0] expS);
    int  lat;
    bit  found;
    @(posedge clk); #1;
    outReady = 1'b1;
    applyStimulus(d, 1'b1);
    @(negedge clk);
    checkOutput({name, "_in_ready"}, 32'(inReady), 32'd1);
    @(posedge clk); #1;
    applyStimulus('0, 1'b0);
    lat   = 1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (outValid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_found"}, 32'(found), 32'd1);
    checkOutput({name, "_latency"}, 32'(lat), 32'd4);
    checkOutput({name, "_sum_u"}, 32'(outSum), 32'(expU));
    checkOutput({name, "_sum_s"}, 32'(outSumS), 32'(expS));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "_pulse_end"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    bit            stallDone;
    int            got;
    int            sent;
    logic [OW-1:0] frozen;
    logic [OW-1:0] exp;
    bit            pat [6];

    compares    = 0;
    miscompares = 0;

    // Hand-computed vectors: {data, unsigned sum, signed sum}.
    vecs[0] = '{pack8(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                      17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), 20'hFFFF8, 20'hFFFF8};
    vecs[1] = '{pack8(17'h10000, 17'h10000, 17'h10000, 17'h10000,
                      17'h10000, 17'h10000, 17'h10000, 17'h10000), 20'h80000, 20'h80000};
    vecs[2] = '{pack8(17'h00001, 17'h1FFFF, 17'h00002, 17'h1FFFE,
                      17'h00003, 17'h1FFFD, 17'h00004, 17'h1FFFC), 20'h80000, 20'h00000};
    vecs[3] = '{pack8(17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0), 20'h0, 20'h0};
    vecs[4] = '{pack8(17'd0, 17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7), 20'h1C, 20'h1C};
    vecs[5] = '{pack8(17'h1FFFF, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0), 20'h1FFFF, 20'hFFFFF};
    vecs[6] = '{pack8(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF,
                      17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF), 20'h7FFF8, 20'h7FFF8};

    rst      = 1'b1;
    outReady = 1'b0;
    applyStimulus('0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_sum", 32'(outSum), 32'd0);
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);

    // Table-driven single vectors.
    for (int i = 0; i < 7; i++) begin
      runOneVector($sformatf("vec%0d", i), vecs[i].data, vecs[i].expU, vecs[i].expS);
    end

    // Streaming: 16 back-to-back vectors, operand i = beat + i.
    @(posedge clk); #1;
    outReady = 1'b1;
    fork
      begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(packSeq(b, 1), 1'b1);
          @(negedge clk);
          checkOutput($sformatf("stream_in_ready%0d", b), 32'(inReady), 32'd1);
          @(posedge clk); #1;
        end
        applyStimulus('0, 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
          @(negedge clk);
          if (outValid) begin
            seen = 1'b1;
            break;
          end
        end
        checkOutput("stream_start", 32'(seen), 32'd1);
        for (int b = 0; b < 16; b++) begin
          if (b > 0) @(negedge clk);
          checkOutput($sformatf("stream_valid%0d", b), 32'(outValid), 32'd1);
          checkOutput($sformatf("stream_sum%0d", b), 32'(outSum), 32'(8*b + 28));
          checkOutput($sformatf("stream_sum_s%0d", b), 32'(outSumS), 32'(8*b + 28));
        end
      end
    join
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stream_drained", 32'(outValid), 32'd0);

    // Backpressure: 10 vectors, stall the consumer for 5 cycles after the first result.
    expQ.delete();
    @(posedge clk); #1;
    outReady = 1'b1;
    fork
      begin
        bit acc;
        sent = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
          applyStimulus(packSeq(100*sent + 5, 2), 1'b1);
          @(negedge clk);
          acc = inReady;
          @(posedge clk); #1;
          if (acc) begin
            expQ.push_back(sumModel(packSeq(100*sent + 5, 2), 1'b0));
            sent++;
          end
        end
        applyStimulus('0, 1'b0);
        checkOutput("bp_all_sent", 32'(sent), 32'd10);
      end
      begin
        got       = 0;
        stallDone = 1'b0;
        for (int c = 0; c < 80 && got < 10; c++) begin
          @(negedge clk);
          if (outValid) begin
            if (expQ.size() == 0) begin
              checkOutput("bp_unexpected", 32'd1, 32'd0);
            end else begin
              exp = expQ.pop_front();
              checkOutput($sformatf("bp_sum%0d", got), 32'(outSum), 32'(exp));
              checkOutput($sformatf("bp_sum_s%0d", got), 32'(outSumS), 32'(exp));
            end
            got++;
            if (!stallDone) begin
              stallDone = 1'b1;
              @(posedge clk); #1;
              outReady = 1'b0;
              for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                checkOutput($sformatf("bp_stall_in_ready%0d", s), 32'(inReady), 32'd0);
                checkOutput($sformatf("bp_stall_valid%0d", s), 32'(outValid), 32'd1);
                if (s == 0) begin
                  frozen = outSum;
                end else begin
                  checkOutput($sformatf("bp_stall_sum%0d", s), 32'(outSum), 32'(frozen));
                end
                @(posedge clk); #1;
              end
              outReady = 1'b1;
            end
          end
        end
        checkOutput("bp_all_received", 32'(got), 32'd10);
      end
    join
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_drained_valid", 32'(outValid), 32'd0);
    checkOutput("bp_drained_queue", 32'(expQ.size()), 32'd0);

    // Bubbles: in_valid 1,0,1,0,0,1 must reappear unchanged 4 cycles later.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    outReady = 1'b1;
    fork
      begin
        for (int c = 0; c < 6; c++) begin
          applyStimulus(packSeq(1000 + 7*c, 3), pat[c]);
          @(posedge clk); #1;
        end
        applyStimulus('0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          checkOutput($sformatf("bubble_valid%0d", c), 32'(outValid), 32'(pat[c]));
          if (pat[c]) begin
            checkOutput($sformatf("bubble_sum%0d", c), 32'(outSum), 32'(8*(1000 + 7*c) + 84));
          end
        end
      end
    join

    // Reset with three vectors in flight.
    @(posedge clk); #1;
    outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(packSeq(50 + c, 1), 1'b1);
      @(posedge clk); #1;
    end
    applyStimulus('0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_valid", 32'(outValid), 32'd0);
    checkOutput("rst_mid_sum", 32'(outSum), 32'd0);
    checkOutput("rst_mid_sum_s", 32'(outSumS), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput($sformatf("rst_no_stale%0d", c), 32'(outValid), 32'd0);
    end
    runOneVector("post_rst", packSeq(9, 4), 20'd184, 20'd184);

    $display("== %0d vectors applied, %0d miscompares ==", compares, miscompares);
    $finish;
  end

endmodule
